// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: request/response bundle between a memory-controller client
// (master) and the mem_ctrl block (slave). Clock and reset are not carried
// here; they stay plain ports on the controller.
interface mem_ctrl_if #(
  parameter int DATA_W = 16
);
  logic              addr_en;
  logic [DATA_W-1:0] addr;
  logic              in_en;
  logic [DATA_W-1:0] in;
  logic              out_en;
  logic              inc_en;
  logic [DATA_W-1:0] out;
  logic              busy;
  logic              ack;
  logic              err;

  modport master (
    output addr_en, addr, in_en, in, out_en, inc_en,
    input  out, busy, ack, err
  );

  modport slave (
    input  addr_en, addr, in_en, in, out_en, inc_en,
    output out, busy, ack, err
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port word memory behind a memory address register (MAR).
// An access is accepted only when idle, takes WAIT_STATES+1 cycles, then
// pulses ack for one cycle. Requests arriving while busy are dropped.
// Out-of-range address loads leave MAR alone and set a sticky err flag.
// Optional feature: define MEM_INIT_EN to preload words 0..4 on reset;
// without it the memory array is never touched by reset.
module mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input logic        clk,
  input logic        rst,
  mem_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_wr_q, lat_wr_d;
  logic              lat_inc_q, lat_inc_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              mem_we;
  logic              addr_oor;
  logic [ADDR_W-1:0] mar_next;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Address range check and wrapping increment of MAR
  assign addr_oor = (32'(bus.addr) >= 32'(DEPTH));
  assign mar_next = (mar_q == ADDR_W'(DEPTH - 1)) ? '0 : mar_q + ADDR_W'(1);

  // Next-state logic: accept in IDLE, count wait states in BUSY, then complete
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    cnt_d      = cnt_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_wr_d   = lat_wr_q;
    lat_inc_d  = lat_inc_q;
    out_d      = out_q;
    ack_d      = 1'b0;
    err_d      = err_q;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.addr_en) begin
          if (addr_oor) begin
            err_d = 1'b1;
          end else begin
            mar_d = bus.addr[ADDR_W-1:0];
          end
        end
        if (bus.in_en || bus.out_en) begin
          state_d    = BUSY;
          cnt_d      = 4'(WAIT_STATES);
          lat_addr_d = mar_q;
          lat_data_d = bus.in;
          lat_wr_d   = bus.in_en;
          lat_inc_d  = bus.inc_en;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          if (lat_wr_q) begin
            mem_we = 1'b1;
          end else begin
            out_d = mem_q[lat_addr_q];
          end
          if (lat_inc_q) begin
            mar_d = mar_next;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mar_q      <= '0;
      cnt_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_wr_q   <= 1'b0;
      lat_inc_q  <= 1'b0;
      out_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      cnt_q      <= cnt_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_wr_q   <= lat_wr_d;
      lat_inc_q  <= lat_inc_d;
      out_q      <= out_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Memory array: commit writes on completion; reset never commits a write
  always_ff @(posedge clk) begin
`ifdef MEM_INIT_EN
    if (rst) begin
      mem_q[0] <= DATA_W'(16'h1500);
      mem_q[1] <= DATA_W'(16'h1701);
      mem_q[2] <= DATA_W'(16'h3430);
      mem_q[3] <= DATA_W'(16'h0220);
      mem_q[4] <= DATA_W'(16'hC002);
    end else if (mem_we) begin
      mem_q[lat_addr_q] <= lat_data_q;
    end
`else
    if (!rst && mem_we) begin
      mem_q[lat_addr_q] <= lat_data_q;
    end
`endif
  end

  assign bus.out  = out_q;
  assign bus.busy = (state_q == BUSY);
  assign bus.ack  = ack_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with two wait
// states, so each access should hold busy for three cycles.
module tb_mem_ctrl;

  localparam int DW = 16;
  localparam int WS = 2;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  mem_ctrl_if #(.DATA_W(DW)) bus ();

  mem_ctrl #(
    .DATA_W(DW),
    .ADDR_W(8),
    .DEPTH(256),
    .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls outside the bounded loops
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic clearInputs();
    bus.addr_en = 1'b0;
    bus.addr    = '0;
    bus.in_en   = 1'b0;
    bus.in      = '0;
    bus.out_en  = 1'b0;
    bus.inc_en  = 1'b0;
  endtask

  task automatic loadAddr(input logic [DW-1:0] a);
    bus.addr_en = 1'b1;
    bus.addr    = a;
    tick();
    bus.addr_en = 1'b0;
  endtask

  // Issue one access, optionally hammer the inputs while busy, and check
  // busy length, the ack pulse and the resulting out value.
  task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                               input logic inc, input logic [DW-1:0] data,
                               input logic [DW-1:0] expOut, input bit noisy);
    int cnt;
    bus.in_en  = wr;
    bus.out_en = rd;
    bus.inc_en = inc;
    bus.in     = data;
    tick();
    clearInputs();
    checkOutput({tag, " ack low while busy"}, 32'(bus.ack), 32'd0);
    cnt = 0;
    while (bus.busy && cnt < 40) begin
      if (noisy) begin
        bus.addr_en = 1'b1;
        bus.addr    = 16'h000A;
        bus.in_en   = 1'b1;
        bus.in      = 16'hFFFF;
        bus.out_en  = 1'b1;
        bus.inc_en  = 1'b1;
      end
      cnt++;
      tick();
    end
    clearInputs();
    checkOutput({tag, " busy cycles"}, 32'(cnt), 32'(WS + 1));
    checkOutput({tag, " ack"}, 32'(bus.ack), 32'd1);
    checkOutput({tag, " out"}, 32'(bus.out), 32'(expOut));
    tick();
    checkOutput({tag, " ack fall"}, 32'(bus.ack), 32'd0);
  endtask

  // Directed scenario sequence
  initial begin
    logic [DW-1:0] mem0Exp;
    checkCount = 0;
    passCount  = 0;
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset out", 32'(bus.out), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset ack", 32'(bus.ack), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);

    // Write then read back at address 3
    loadAddr(16'd3);
    checkOutput("load3 busy", 32'(bus.busy), 32'd0);
    applyStimulus("wr3", 1'b1, 1'b0, 1'b0, 16'hABCD, 16'h0000, 1'b0);
    applyStimulus("rd3", 1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1'b0);

    // Requests while busy must be dropped: MAR and mem[3] unchanged
    applyStimulus("rd3 noisy", 1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1'b1);
    applyStimulus("rd3 again", 1'b0, 1'b1, 1'b0, 16'h0000, 16'hABCD, 1'b0);
    checkOutput("noisy err", 32'(bus.err), 32'd0);

    // Post-increment writes, then wrap from 255 to 0
    loadAddr(16'd0);
    applyStimulus("wr0 inc", 1'b1, 1'b0, 1'b1, 16'h1111, 16'hABCD, 1'b0);
    applyStimulus("wr1 inc", 1'b1, 1'b0, 1'b1, 16'h2222, 16'hABCD, 1'b0);
    loadAddr(16'd255);
    checkOutput("load255 err", 32'(bus.err), 32'd0);
    applyStimulus("wr255 inc", 1'b1, 1'b0, 1'b1, 16'h00FF, 16'hABCD, 1'b0);
    applyStimulus("rd after wrap", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 1'b0);

    // Address load on the accept edge: access uses old MAR (0), MAR becomes 1
    bus.addr_en = 1'b1;
    bus.addr    = 16'd1;
    applyStimulus("rd old mar", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1111, 1'b0);
    applyStimulus("rd new mar", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222, 1'b0);

    // Write and read together: write wins, out unchanged
    loadAddr(16'd2);
    applyStimulus("wr+rd", 1'b1, 1'b1, 1'b0, 16'h1234, 16'h2222, 1'b0);
    applyStimulus("rd2", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0);

    // Out-of-range load: err set, MAR stays at 2, err is sticky
    loadAddr(16'h0100);
    checkOutput("oor err", 32'(bus.err), 32'd1);
    applyStimulus("rd after oor", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1234, 1'b0);
    checkOutput("err sticky", 32'(bus.err), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("err cleared", 32'(bus.err), 32'd0);
    checkOutput("out cleared", 32'(bus.out), 32'd0);

    // Reset one cycle after accepting a write aborts it
    loadAddr(16'd7);
    applyStimulus("wr7", 1'b1, 1'b0, 1'b0, 16'h7777, 16'h0000, 1'b0);
    bus.in_en = 1'b1;
    bus.in    = 16'h5555;
    tick();
    clearInputs();
    checkOutput("abort accepted", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort ack", 32'(bus.ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("abort no ack", 32'(bus.ack), 32'd0);
    end
`ifdef MEM_INIT_EN
    mem0Exp = 16'h1500;
`else
    mem0Exp = 16'h1111;
`endif
    applyStimulus("rd mar0 after rst", 1'b0, 1'b1, 1'b0, 16'h0000, mem0Exp, 1'b0);
    loadAddr(16'd7);
    applyStimulus("rd7 kept", 1'b0, 1'b1, 1'b0, 16'h0000, 16'h7777, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
